// File: rtl/xm23_pkg.sv
// xm23_pkg: shared types and widths for the XM23 instruction fetch stage.
//   INST_W / ADDR_W  : instruction word and byte-address widths
//   fetch_state_t    : fetch FSM encoding
//   fetch_entry_t    : one instruction buffer entry {inst, pc}
package xm23_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: synchronous FIFO of fetch_entry_t used as the fetch instruction buffer.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (clears pointers, count, storage)
//   push        : write push_data at the tail (ignored when full unless popping)
//   push_data   : entry to write
//   pop         : remove the head entry (ignored when empty)
//   flush       : empty the buffer; overrides push and pop in the same cycle
//   head        : current head entry (registered storage, no bypass from push_data)
//   count       : number of valid entries, 0..DEPTH
//   empty, full : status flags derived from count
import xm23_pkg::*;

module fetch_buf #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: XM23 instruction fetch stage. Owns the PC, issues single outstanding
// reads to instruction memory, buffers returned words and hands them to the decoder
// with a valid/ready handshake. A redirect flushes the buffer and squashes any
// in-flight read.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   imem_req     : one-cycle read request pulse
//   imem_addr    : byte address of the read (always the current PC, bit 0 = 0)
//   imem_valid   : read data returned this cycle
//   imem_rdata   : returned instruction word
//   inst_valid   : buffer head holds a valid instruction
//   inst_ready   : decoder accepts the head this cycle
//   inst,inst_pc : head instruction word and its address
//   redirect     : branch taken / PC write from execute
//   redirect_pc  : new fetch address (bit 0 forced to 0)
import xm23_pkg::*;

module inst_fetch #(
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned       CNT_W     = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(2);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              buf_push;
  logic              buf_flush;
  logic              buf_empty;
  logic              buf_full;
  logic [CNT_W-1:0]  buf_count;
  fetch_entry_t      buf_head;
  fetch_entry_t      buf_wdata;

  logic              pop;
  logic [CNT_W-1:0]  count_after_pop;
  logic              has_space;

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .push_data(buf_wdata),
    .pop      (pop),
    .flush    (buf_flush),
    .head     (buf_head),
    .count    (buf_count),
    .empty    (buf_empty),
    .full     (buf_full)
  );

  assign inst_valid = !buf_empty;
  assign inst       = buf_head.inst;
  assign inst_pc    = buf_head.pc;
  assign imem_addr  = pc_q;

  assign pop             = inst_valid && inst_ready;
  // Space is judged after this cycle's pop, so a full buffer being drained still fetches.
  assign count_after_pop = buf_count - {{(CNT_W-1){1'b0}}, pop};
  assign has_space       = (count_after_pop < CNT_DEPTH);

  assign buf_wdata = '{inst: imem_rdata, pc: pc_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    imem_req  = 1'b0;
    buf_push  = 1'b0;
    buf_flush = 1'b0;

    if (redirect) begin
      // Redirect wins over everything: flush, retarget, and if a read is in flight
      // either drop its data now (arriving this cycle) or drain it later.
      buf_flush = 1'b1;
      pc_d      = {redirect_pc[ADDR_W-1:1], 1'b0};
      if (state_q == WAIT) begin
        state_d = imem_valid ? FETCH : DRAIN;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (has_space && !rst) begin
            imem_req = 1'b1;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_valid) begin
            buf_push = !buf_full || pop;
            pc_d     = pc_q + PC_STEP;
            state_d  = FETCH;
          end
        end
        DRAIN: begin
          if (imem_valid) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
